// File: rtl/tbb1143_pkg.sv
// tbb1143_pkg: shared state, command and default timing definitions for the TBB1143 bus writer
package tbb1143_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    typedef struct packed {
        logic       a0;
        logic [3:0] d;
    } cmd_t;

    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_PULSE_CYC  = 2;
    localparam int DEF_HOLD_CYC   = 1;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/tbb1143_cmd_fifo.sv
// tbb1143_cmd_fifo: command FIFO with occupancy count, pointers wrap modulo DEPTH
module tbb1143_cmd_fifo
    import tbb1143_pkg::*;
#(
    parameter  int DEPTH = DEF_FIFO_DEPTH,
    localparam int LW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          push,
    input  logic          pop,
    input  cmd_t          wdata,
    output cmd_t          rdata,
    output logic [LW-1:0] level
);

    cmd_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
        end
    end

endmodule

// File: rtl/tbb1143_bus_writer.sv
// tbb1143_bus_writer: replays queued nibble commands onto the TBB1143 parallel bus with timed WR strobe
module tbb1143_bus_writer
    import tbb1143_pkg::*;
#(
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter  int SETUP_CYC  = DEF_SETUP_CYC,
    parameter  int PULSE_CYC  = DEF_PULSE_CYC,
    parameter  int HOLD_CYC   = DEF_HOLD_CYC,
    localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic          IN_A0,
    input  logic [3:0]    IN_D,
    output logic          A0,
    output logic [3:0]    D,
    output logic          WR,
    output logic          DONE,
    output logic          BUSY,
    output logic [LW-1:0] LEVEL
);

    localparam int CW = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam logic [CW-1:0] S_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] P_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] H_LD = CW'(HOLD_CYC - 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          pop;
    logic          push;
    cmd_t          wcmd;
    cmd_t          head;

    assign wcmd     = '{a0: IN_A0, d: IN_D};
    assign IN_READY = LEVEL != LW'(FIFO_DEPTH);
    assign push     = IN_VALID & IN_READY;
    assign BUSY     = (state != IDLE) || (LEVEL != '0);

    tbb1143_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK  (CLK),
        .RST_N(RST_N),
        .push (push),
        .pop  (pop),
        .wdata(wcmd),
        .rdata(head),
        .level(LEVEL)
    );

    // each phase loads its length minus one and ends when the counter reaches zero
    always_comb begin
        state_nx = state;
        cnt_nx   = (cnt == '0) ? cnt : cnt - 1'b1;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (LEVEL != '0) begin
                    pop      = 1'b1;
                    state_nx = SETUP;
                    cnt_nx   = S_LD;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nx = STROBE;
                    cnt_nx   = P_LD;
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_nx = HOLD;
                    cnt_nx   = H_LD;
                end
            end
            default: begin
                if (cnt == '0) begin
                    pop      = LEVEL != '0;
                    state_nx = pop ? SETUP : IDLE;
                    cnt_nx   = pop ? S_LD : '0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
            A0    <= 1'b0;
            D     <= 4'h0;
            WR    <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            WR    <= state_nx == STROBE;
            DONE  <= (state_nx == HOLD) && (cnt_nx == '0);
            if (pop) begin
                A0 <= head.a0;
                D  <= head.d;
            end
        end
    end

endmodule

// File: tb/tb_tbb1143_bus_writer.sv
// tb_tbb1143_bus_writer: randomized check of two writer configurations against a queue-based timing model
module tb_tbb1143_bus_writer;

    localparam int DEPTH  = 4;
    localparam int PS [2] = '{1, 2};
    localparam int PP [2] = '{2, 3};
    localparam int PH [2] = '{1, 2};

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic [1:0] vld, ia0, rdy, a0o, wr, done, busy;
    logic [3:0] id  [2];
    logic [3:0] dq  [2];
    logic [2:0] lvl [2];

    logic [4:0] q [2][$];
    bit         act [2];
    int         t [2];
    logic       ma0 [2];
    logic [3:0] md [2];
    bit         acc [2];
    int         done_cnt [2];
    int         sent [2];
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 CLK = ~CLK;

    tbb1143_bus_writer dut0 (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(vld[0]), .IN_READY(rdy[0]), .IN_A0(ia0[0]), .IN_D(id[0]),
        .A0(a0o[0]), .D(dq[0]), .WR(wr[0]), .DONE(done[0]), .BUSY(busy[0]), .LEVEL(lvl[0])
    );

    tbb1143_bus_writer #(.FIFO_DEPTH(4), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(vld[1]), .IN_READY(rdy[1]), .IN_A0(ia0[1]), .IN_D(id[1]),
        .A0(a0o[1]), .D(dq[1]), .WR(wr[1]), .DONE(done[1]), .BUSY(busy[1]), .LEVEL(lvl[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset(input int m);
        q[m].delete();
        act[m] = 1'b0;
        t[m]   = 0;
        ma0[m] = 1'b0;
        md[m]  = 4'h0;
        acc[m] = 1'b0;
    endfunction

    // a write in progress is tracked only by its cycle offset t since the pop
    function automatic void model_step(input int m);
        int len;
        int sz;
        logic [4:0] c;
        if (!RST_N) begin
            model_reset(m);
            return;
        end
        len    = PS[m] + PP[m] + PH[m];
        sz     = q[m].size();
        acc[m] = vld[m] && (sz != DEPTH);
        if (sz > 0 && (!act[m] || t[m] == len - 1)) begin
            c      = q[m].pop_front();
            ma0[m] = c[4];
            md[m]  = c[3:0];
            act[m] = 1'b1;
            t[m]   = 0;
        end else if (act[m] && t[m] == len - 1) begin
            act[m] = 1'b0;
        end else if (act[m]) begin
            t[m]++;
        end
        if (acc[m]) q[m].push_back({ia0[m], id[m]});
    endfunction

    function automatic bit exp_wr(input int m);
        return act[m] && t[m] >= PS[m] && t[m] < PS[m] + PP[m];
    endfunction

    function automatic bit model_idle();
        return !act[0] && !act[1] && q[0].size() == 0 && q[1].size() == 0;
    endfunction

    task automatic check_outputs(input int m);
        chk($sformatf("wr%0d", m), wr[m], exp_wr(m));
        chk($sformatf("done%0d", m), done[m], act[m] && t[m] == PS[m] + PP[m] + PH[m] - 1);
        chk($sformatf("a0_%0d", m), a0o[m], ma0[m]);
        chk($sformatf("d%0d", m), dq[m], md[m]);
        chk($sformatf("level%0d", m), lvl[m], q[m].size());
        chk($sformatf("ready%0d", m), rdy[m], q[m].size() != DEPTH);
        chk($sformatf("busy%0d", m), busy[m], act[m] || q[m].size() != 0);
    endtask

    task automatic tick();
        @(posedge CLK);
        for (int m = 0; m < 2; m++) model_step(m);
        @(negedge CLK);
        for (int m = 0; m < 2; m++) begin
            check_outputs(m);
            done_cnt[m] += int'(done[m]);
            if (acc[m]) vld[m] = 1'b0;
        end
    endtask

    task automatic offer(input int m, input logic a, input logic [3:0] dd);
        vld[m] = 1'b1;
        ia0[m] = a;
        id[m]  = dd;
    endtask

    task automatic wait_accept(input string tag);
        for (int w = 0; w < 60 && vld != 2'b00; w++) tick();
        chk(tag, vld, 2'b00);
    endtask

    task automatic drain(input string tag);
        for (int w = 0; w < 300 && !model_idle(); w++) tick();
        chk(tag, model_idle(), 1'b1);
        repeat (2) tick();
    endtask

    initial begin
        vld    = 2'b00;
        ia0    = 2'b00;
        id[0]  = 4'h0;
        id[1]  = 4'h0;
        repeat (3) tick();
        RST_N = 1'b1;
        tick();

        for (int m = 0; m < 2; m++) offer(m, 1'b1, 4'hA);
        wait_accept("single_acc");
        drain("single_drain");

        done_cnt = '{0, 0};
        for (int k = 1; k <= 6; k++) begin
            for (int m = 0; m < 2; m++) offer(m, k[0], k[3:0]);
            wait_accept("burst_acc");
        end
        drain("burst_drain");
        chk("burst_done0", done_cnt[0], 6);
        chk("burst_done1", done_cnt[1], 6);

        for (int k = 1; k <= 4; k++) begin
            for (int m = 0; m < 2; m++) offer(m, 1'b0, 4'(k + 8));
            wait_accept("rst_fill");
        end
        begin
            bit hit = 1'b0;
            for (int w = 0; w < 30 && !hit; w++) begin
                hit = exp_wr(0) && q[0].size() == 3;
                if (!hit) tick();
            end
            chk("strobe_wait", hit, 1'b1);
        end
        #2 RST_N = 1'b0;
        vld = 2'b00;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("arst_wr%0d", m), wr[m], 1'b0);
            chk($sformatf("arst_level%0d", m), lvl[m], 0);
            chk($sformatf("arst_ready%0d", m), rdy[m], 1'b1);
            model_reset(m);
        end
        repeat (2) tick();
        RST_N = 1'b1;
        done_cnt = '{0, 0};
        repeat (20) tick();
        chk("post_rst_done", done_cnt[0] + done_cnt[1], 0);

        sent = '{0, 0};
        done_cnt = '{0, 0};
        for (int c = 0; c < 3000 && (sent[0] < 10 || sent[1] < 10 || vld != 2'b00 || !model_idle()); c++) begin
            for (int m = 0; m < 2; m++)
                if (!vld[m] && sent[m] < 10 && $urandom_range(0, 3) == 0) begin
                    offer(m, 1'($urandom), 4'($urandom));
                    sent[m]++;
                end
            tick();
        end
        chk("rand_idle", model_idle() && vld == 2'b00, 1'b1);
        chk("rand_done0", done_cnt[0], 10);
        chk("rand_done1", done_cnt[1], 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
